iomem_initiator: RTL

//  CPU-side master of the iomem block bus: arbitrates I-cache line refills and D-cache

---
 rtl/tcore_mem_pkg.sv | 27 ++
 rtl/iomem_rr_arb2.sv | 36 +++
 rtl/iomem_initiator.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tcore_mem_pkg.sv
// ============================================================================
// Module  : tcore_mem_pkg
// Purpose : Shared memory-side types and constants for the cpu's bus masters.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tcore_mem_pkg;

    localparam int BLOCK_SIZE  = 128;
    localparam int NUMS_BYTE   = BLOCK_SIZE / 8;
    localparam int BYTE_OFFSET = $clog2(NUMS_BYTE);

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/iomem_rr_arb2.sv
// ============================================================================
// Module  : iomem_rr_arb2
// Purpose : Two-way round-robin arbiter; bit 0 = I-cache, bit 1 = D-cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iomem_rr_arb2 (
    input  logic       clk_o,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_prio_dc;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_prio_dc ? 2'b10 : 2'b01;
        end
    end

    // After an I grant the D side is preferred next, and vice versa.
    always_ff @(posedge clk_o) begin
        if (!rst_n) begin
            r_prio_dc <= 1'b1;
        end else if (i_advance && (|o_grant)) begin
            r_prio_dc <= o_grant[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/iomem_initiator.sv
// ============================================================================
// Module  : iomem_initiator
// Purpose : Arbitrates I/D cache requests onto one iomem port and returns data.
//           Optional bus timeout enabled by macro IOMEM_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iomem_initiator #(
    parameter int BLOCK_SIZE  = tcore_mem_pkg::BLOCK_SIZE,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk_o,
    input  logic                    rst_n,
    input  logic                    ic_req_valid_i,
    output logic                    ic_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   ic_req_addr_i,
    output logic                    ic_rsp_valid_o,
    output logic [BLOCK_SIZE-1:0]   ic_rsp_data_o,
    output logic                    ic_rsp_err_o,
    input  logic                    dc_req_valid_i,
    output logic                    dc_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   dc_req_addr_i,
    input  logic [BLOCK_SIZE/8-1:0] dc_req_wstrb_i,
    input  logic [BLOCK_SIZE-1:0]   dc_req_wdata_i,
    output logic                    dc_rsp_valid_o,
    output logic [BLOCK_SIZE-1:0]   dc_rsp_data_o,
    output logic                    dc_rsp_err_o,
    output logic                    iomem_valid_o,
    input  logic                    iomem_ready_i,
    output logic [ADDR_WIDTH-1:0]   iomem_addr_o,
    output logic [BLOCK_SIZE/8-1:0] iomem_wstrb_o,
    output logic [BLOCK_SIZE-1:0]   iomem_wdata_o,
    input  logic [BLOCK_SIZE-1:0]   iomem_rdata_i,
    output logic                    busy_o
);

    import tcore_mem_pkg::*;

    localparam int NB = BLOCK_SIZE / 8;

    state_e                r_state;
    state_e                w_state_nxt;
    owner_e                r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NB-1:0]         r_wstrb;
    logic [BLOCK_SIZE-1:0] r_wdata;
    logic [BLOCK_SIZE-1:0] r_rdata;
    logic [1:0]            w_grant;
    logic                  w_idle;
    logic                  w_accept;
    logic                  w_timeout;
    logic                  w_err;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && (ic_req_valid_i || dc_req_valid_i);

    iomem_rr_arb2 u_arb (
        .clk_o     (clk_o),
        .rst_n     (rst_n),
        .i_req     ({dc_req_valid_i, ic_req_valid_i}),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

`ifdef IOMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_err;

    always_ff @(posedge clk_o) begin
        if (!rst_n || (r_state != BUS)) begin
            r_tmo_cnt <= '0;
        end else if (!iomem_ready_i) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // A ready in the final counted cycle takes precedence over the abort.
    assign w_timeout = (r_state == BUS) && !iomem_ready_i &&
                       (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_o) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == BUS) begin
            r_err <= w_timeout;
        end
    end

    assign w_err = r_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC != 0);
    assign w_timeout    = 1'b0;
    assign w_err        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = BUS;
            BUS:     if (iomem_ready_i || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_o) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= OWN_IC;
            r_addr  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner <= w_grant[1] ? OWN_DC : OWN_IC;
                r_addr  <= w_grant[1] ? dc_req_addr_i  : ic_req_addr_i;
                r_wstrb <= w_grant[1] ? dc_req_wstrb_i : '0;
                r_wdata <= w_grant[1] ? dc_req_wdata_i : '0;
            end
            if ((r_state == BUS) && iomem_ready_i) begin
                r_rdata <= iomem_rdata_i;
            end else if (w_timeout) begin
                r_rdata <= '0;
            end
        end
    end

    assign ic_req_ready_o = w_idle && w_grant[0];
    assign dc_req_ready_o = w_idle && w_grant[1];

    assign iomem_valid_o  = (r_state == BUS);
    assign iomem_addr_o   = r_addr;
    assign iomem_wstrb_o  = r_wstrb;
    assign iomem_wdata_o  = r_wdata;
    assign busy_o         = !w_idle;

    assign ic_rsp_valid_o = (r_state == RESP) && (r_owner == OWN_IC);
    assign dc_rsp_valid_o = (r_state == RESP) && (r_owner == OWN_DC);
    assign ic_rsp_err_o   = ic_rsp_valid_o && w_err;
    assign dc_rsp_err_o   = dc_rsp_valid_o && w_err;
    assign ic_rsp_data_o  = r_rdata;
    assign dc_rsp_data_o  = r_rdata;

endmodule

`default_nettype wire
